round_robin_arb_8x3: RTL
========================

ROUND_ROBIN_ARB_8X3 -- requirements
Module: round_robin_arb_8x3

Interface
REQ-001 The module SHALL have parameter MAX_HOLD, default 16: the maximum number of consecutive cycles one grant is held; legal range 1..255.
REQ-002 The module SHALL have port clk, input, 1 bit: the single clock; all state updates on its rising edge.
REQ-003 The module SHALL have port rst, input, 1 bit: reset, synchronous and active-high.
REQ-004 The module SHALL have port req, input, 8 bits: request lines, bit i = requester i.
REQ-005 The module SHALL have port done, input, 1 bit: the current holder releases the shared resource.
REQ-006 The module SHALL have port gnt, output, 8 bits: registered one-hot grant.
REQ-007 The module SHALL have port gnt_idx, output, 3 bits: registered binary index of the granted bit, i.e. the 8-to-3 encoding of gnt.
REQ-008 The module SHALL have port gnt_valid, output, 1 bit: high while a grant is held.
REQ-009 The module SHALL have port timeout, output, 1 bit: one-cycle pulse when a grant is revoked by MAX_HOLD.

Function
REQ-010 The module SHALL implement two states: IDLE and BUSY.
REQ-011 In IDLE with req != 0, the module SHALL select the first set req bit at or after pointer ptr, scanning ascending with wrap 7->0.
REQ-012 In IDLE with req != 0, the module SHALL on the next edge assert gnt_valid, set gnt to the selected one-hot value and gnt_idx to its index, and enter BUSY, for a latency of 1 cycle.
REQ-013 In IDLE with req == 0, the module SHALL keep all outputs at 0 and ptr unchanged.
REQ-014 In BUSY, gnt and gnt_idx SHALL remain constant, and changes on non-holder req bits SHALL be ignored.
REQ-015 In BUSY, the hold counter SHALL be 1 on the first gnt_valid cycle and increment by 1 each subsequent BUSY cycle.
REQ-016 In BUSY, a release SHALL occur when done=1, or req[gnt_idx]=0, or the hold counter equals MAX_HOLD.
REQ-017 On release, the next edge SHALL clear gnt, gnt_idx and gnt_valid, set ptr = (gnt_idx+1) mod 8, clear the counter, and enter IDLE.
REQ-018 Every release SHALL be followed by at least one IDLE cycle with gnt_valid=0; back-to-back grants are not allowed.
REQ-019 gnt_valid SHALL be high for at most MAX_HOLD consecutive cycles.
REQ-020 timeout SHALL pulse high for exactly the one cycle after a release caused solely by the counter.
REQ-021 If done=1 or the holder's req drop occurs in the same cycle the counter reaches MAX_HOLD, the release SHALL count as normal and timeout SHALL stay 0.
REQ-022 gnt SHALL never have more than one bit set.
REQ-023 gnt_idx SHALL be 0 whenever gnt_valid=0; the outputs are never X.
REQ-024 done asserted in IDLE SHALL have no effect.
REQ-025 With MAX_HOLD=1, each grant SHALL last exactly 1 cycle, and timeout SHALL pulse unless done or the holder's req drop coincides.

Reset
REQ-026 When rst=1 at a clock edge, the module SHALL force IDLE, ptr=0, counter=0, gnt=8'h00, gnt_idx=3'd0, gnt_valid=0 and timeout=0.
REQ-027 Reset SHALL take priority over every other event.
REQ-028 Reset asserted mid-grant SHALL drop the grant on that edge without pulsing timeout.
REQ-029 After rst deasserts, the first grant SHALL follow REQ-011 with ptr=0.

Verification
REQ-030 The bench SHALL cover: after reset, req=8'b1010_0100 -> one cycle later gnt=8'b0000_0100, gnt_idx=2, gnt_valid=1.
REQ-031 The bench SHALL cover: requester 2 holds, done=1, req stays 8'b1010_0100 -> one IDLE cycle, then gnt=8'b0010_0000, gnt_idx=5.
REQ-032 The bench SHALL cover: req=8'hFF with done pulsed each grant -> gnt_idx sequence 0,1,...,7,0 with an IDLE cycle between each grant (wrap check).
REQ-033 The bench SHALL cover: MAX_HOLD=16, req[3] held, done=0 -> gnt_valid high exactly 16 cycles, then timeout=1 for one cycle, and the next grant goes to index 4 or later.
REQ-034 The bench SHALL cover: done=1 on the 16th hold cycle -> release with timeout=0.
REQ-035 The bench SHALL cover: rst=1 during BUSY with gnt_idx=6 -> next cycle all outputs 0, and next req=8'h40 is granted index 6 through the ptr=0 scan.

Source files
------------

// File: rtl/round_robin_arb_8x3.sv
// round_robin_arb_8x3
//   8-requester round-robin arbiter with a bounded hold time.
//   A grant is issued one cycle after a request is seen in IDLE, held until
//   the holder signals done, drops its request, or MAX_HOLD cycles elapse,
//   and is always followed by at least one idle cycle.
//
// Ports
//   clk        rising-edge clock
//   rst        synchronous active-high reset
//   req[7:0]   request lines, bit i = requester i
//   done       current holder releases the resource
//   gnt[7:0]   registered one-hot grant
//   gnt_idx    registered binary index of gnt (0 when no grant)
//   gnt_valid  high while a grant is held
//   timeout    one-cycle pulse after a grant is revoked by the hold limit
module round_robin_arb_8x3 #(
  parameter int MAX_HOLD = 16
) (
  input  logic       clk,
  input  logic       rst,
  input  logic [7:0] req,
  input  logic       done,
  output logic [7:0] gnt,
  output logic [2:0] gnt_idx,
  output logic       gnt_valid,
  output logic       timeout
);

  localparam logic [7:0] MaxHold = 8'(MAX_HOLD);

  typedef enum logic {IDLE, BUSY} state_t;

  state_t     state_q, state_d;
  logic [2:0] ptr_q, ptr_d;
  logic [7:0] cnt_q, cnt_d;
  logic [7:0] gnt_q, gnt_d;
  logic [2:0] gnt_idx_q, gnt_idx_d;
  logic       gnt_valid_q, gnt_valid_d;
  logic       timeout_q, timeout_d;

  logic [2:0] sel_idx;
  logic [2:0] cand;
  logic       early_rel;

  // Round-robin pick: walk offsets from the far end back to 0 so the
  // request closest to ptr (ascending, wrapping) is the last one written.
  always_comb begin
    sel_idx = 3'd0;
    cand    = 3'd0;
    for (int k = 7; k >= 0; k--) begin
      cand = ptr_q + 3'(k);
      if (req[cand]) sel_idx = cand;
    end
  end

  always_comb begin
    state_d     = state_q;
    ptr_d       = ptr_q;
    cnt_d       = cnt_q;
    gnt_d       = gnt_q;
    gnt_idx_d   = gnt_idx_q;
    gnt_valid_d = gnt_valid_q;
    timeout_d   = 1'b0;
    // Holder-initiated release; takes precedence over the hold limit so a
    // coincident done/req drop never reports a timeout.
    early_rel   = done | ~req[gnt_idx_q];
    case (state_q)
      IDLE: begin
        if (|req) begin
          state_d     = BUSY;
          gnt_d       = 8'b1 << sel_idx;
          gnt_idx_d   = sel_idx;
          gnt_valid_d = 1'b1;
          cnt_d       = 8'd1;
        end
      end
      BUSY: begin
        if (early_rel || cnt_q == MaxHold) begin
          state_d     = IDLE;
          gnt_d       = 8'h00;
          gnt_idx_d   = 3'd0;
          gnt_valid_d = 1'b0;
          cnt_d       = 8'd0;
          ptr_d       = gnt_idx_q + 3'd1;
          timeout_d   = ~early_rel;
        end else begin
          cnt_d = cnt_q + 8'd1;
        end
      end
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q     <= IDLE;
      ptr_q       <= 3'd0;
      cnt_q       <= 8'd0;
      gnt_q       <= 8'h00;
      gnt_idx_q   <= 3'd0;
      gnt_valid_q <= 1'b0;
      timeout_q   <= 1'b0;
    end else begin
      state_q     <= state_d;
      ptr_q       <= ptr_d;
      cnt_q       <= cnt_d;
      gnt_q       <= gnt_d;
      gnt_idx_q   <= gnt_idx_d;
      gnt_valid_q <= gnt_valid_d;
      timeout_q   <= timeout_d;
    end
  end

  assign gnt       = gnt_q;
  assign gnt_idx   = gnt_idx_q;
  assign gnt_valid = gnt_valid_q;
  assign timeout   = timeout_q;

endmodule
